// File: rtl/warp_ctx.sv
// Per-warp context controller: PC, active mask, issue/writeback sequencing and
// warp-stack interface. Optional perf counters are enabled by WARP_CTX_PERF_EN.
module warp_ctx #(
    parameter int I_ADDR_WIDTH = 10,
    parameter int WARP_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [I_ADDR_WIDTH-1:0] start_pc,
    input  logic [WARP_WIDTH-1:0]   start_mask,
    input  logic                    issue_grant,
    input  logic                    wb,
    input  logic                    branch,
    input  logic [I_ADDR_WIDTH-1:0] branch_pc,
    input  logic [WARP_WIDTH-1:0]   taken_mask,
    input  logic                    exit,
    input  logic                    contention,
    input  logic [WARP_WIDTH-1:0]   ldst_done_mask,
    input  logic [I_ADDR_WIDTH-1:0] pc_o,
    input  logic [WARP_WIDTH-1:0]   smask_o,
    input  logic                    mask_update,
    input  logic                    converge,
    input  logic                    pc_update,
    output logic                    ready,
    output logic                    done,
    output logic                    err,
    output logic [I_ADDR_WIDTH-1:0] cur_pc,
    output logic [I_ADDR_WIDTH-1:0] cur_pc_p1,
    output logic [WARP_WIDTH-1:0]   cur_mask,
    output logic                    wup,
    output logic                    diverge,
    output logic [WARP_WIDTH-1:0]   stack_mask_i
`ifdef WARP_CTX_PERF_EN
    ,
    output logic [31:0]             perf_retired,
    output logic [31:0]             perf_diverge
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READY = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t                  state, state_nx;
    logic [I_ADDR_WIDTH-1:0] pc_nx, wb_pc;
    logic [WARP_WIDTH-1:0]   mask_nx, wb_mask, eff;
    logic                    err_nx, start_acc;

    assign cur_pc_p1 = cur_pc + I_ADDR_WIDTH'(1);

    always_comb begin
        eff          = taken_mask & cur_mask;
        ready        = (state == READY);
        done         = (state == DONE);
        wup          = wb & (state == WAIT);
        diverge      = wup & branch & ~contention & (eff != '0) & (eff != cur_mask);
        stack_mask_i = '0;
        if (contention)
            stack_mask_i = cur_mask;
        else if (diverge)
            stack_mask_i = cur_mask & ~taken_mask;
    end

    // Writeback outcome in priority order; exit is resolved in the FSM below.
    always_comb begin
        wb_pc   = cur_pc_p1;
        wb_mask = cur_mask;
        if (contention) begin
            wb_pc   = cur_pc;
            wb_mask = cur_mask & ~ldst_done_mask;
        end else if (pc_update) begin
            wb_pc   = pc_o;
            wb_mask = smask_o;
        end else if (converge) begin
            wb_mask = cur_mask | smask_o;
        end else if (mask_update) begin
            wb_mask = smask_o;
        end else if (diverge) begin
            wb_pc   = branch_pc;
            wb_mask = eff;
        end else if (branch && (eff == cur_mask)) begin
            wb_pc   = branch_pc;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = cur_pc;
        mask_nx   = cur_mask;
        err_nx    = err;
        start_acc = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = READY;
                    pc_nx     = start_pc;
                    mask_nx   = start_mask;
                    err_nx    = 1'b0;
                    start_acc = 1'b1;
                end
            end
            READY: begin
                if (issue_grant)
                    state_nx = WAIT;
            end
            WAIT: begin
                if (wb) begin
                    if (exit) begin
                        state_nx = DONE;
                    end else begin
                        pc_nx   = wb_pc;
                        mask_nx = wb_mask;
                        if (wb_mask == '0) begin
                            state_nx = DONE;
                            err_nx   = 1'b1;
                        end else begin
                            state_nx = READY;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_pc   <= '0;
            cur_mask <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            cur_pc   <= pc_nx;
            cur_mask <= mask_nx;
            err      <= err_nx;
        end
    end

`ifdef WARP_CTX_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired <= '0;
            perf_diverge <= '0;
        end else if (start_acc) begin
            perf_retired <= '0;
            perf_diverge <= '0;
        end else begin
            if (wup && !contention && perf_retired != '1)
                perf_retired <= perf_retired + 32'd1;
            if (diverge && perf_diverge != '1)
                perf_diverge <= perf_diverge + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_warp_ctx.sv
// Self-checking bench for warp_ctx: directed scenarios then randomized traffic
// against a behavioural model of the warp context.
module tb_warp_ctx;

    localparam int AW = 10;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst, start, issue_grant, wb, branch, exit, contention;
    logic          mask_update, converge, pc_update;
    logic [AW-1:0] start_pc, branch_pc, pc_o;
    logic [WW-1:0] start_mask, taken_mask, ldst_done_mask, smask_o;
    logic          ready, done, err, wup, diverge;
    logic [AW-1:0] cur_pc, cur_pc_p1;
    logic [WW-1:0] cur_mask, stack_mask_i;
`ifdef WARP_CTX_PERF_EN
    logic [31:0]   perf_retired, perf_diverge;
`endif

    always #5 clk = ~clk;

    warp_ctx #(.I_ADDR_WIDTH(AW), .WARP_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .start_mask(start_mask),
        .issue_grant(issue_grant), .wb(wb), .branch(branch), .branch_pc(branch_pc),
        .taken_mask(taken_mask), .exit(exit), .contention(contention),
        .ldst_done_mask(ldst_done_mask), .pc_o(pc_o), .smask_o(smask_o),
        .mask_update(mask_update), .converge(converge), .pc_update(pc_update),
        .ready(ready), .done(done), .err(err), .cur_pc(cur_pc), .cur_pc_p1(cur_pc_p1),
        .cur_mask(cur_mask), .wup(wup), .diverge(diverge), .stack_mask_i(stack_mask_i)
`ifdef WARP_CTX_PERF_EN
        , .perf_retired(perf_retired), .perf_diverge(perf_diverge)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: warp phase plus architectural PC/mask.
    typedef enum {M_IDLE, M_READY, M_WAIT, M_DONE} mphase_t;
    mphase_t       m_ph;
    int            m_pc;
    logic [WW-1:0] m_mask;
    bit            m_err;
    longint        m_ret, m_div;

    function automatic int pc_inc(input int pc);
        return (pc + 1) % (1 << AW);
    endfunction

    function automatic bit m_wup();
        return wb && (m_ph == M_WAIT);
    endfunction

    function automatic bit m_diverges();
        logic [WW-1:0] e;
        e = taken_mask & m_mask;
        return m_wup() && branch && !contention && (e != 0) && (e != m_mask);
    endfunction

    task automatic model_reset();
        m_ph = M_IDLE; m_pc = 0; m_mask = '0; m_err = 0; m_ret = 0; m_div = 0;
    endtask

    task automatic model_clock();
        logic [WW-1:0] e, nm;
        int np;
        e = taken_mask & m_mask;
        if (m_ph == M_IDLE || m_ph == M_DONE) begin
            if (start) begin
                m_ph = M_READY; m_pc = int'(start_pc); m_mask = start_mask;
                m_err = 0; m_ret = 0; m_div = 0;
            end
        end else if (m_ph == M_READY) begin
            if (issue_grant) m_ph = M_WAIT;
        end else if (wb) begin
            if (!contention && m_ret < 64'hFFFF_FFFF) m_ret++;
            if (m_diverges() && m_div < 64'hFFFF_FFFF) m_div++;
            np = pc_inc(m_pc); nm = m_mask;
            if (contention)                    begin np = m_pc; nm = m_mask & ~ldst_done_mask; end
            else if (pc_update)                begin np = int'(pc_o); nm = smask_o; end
            else if (converge)                 nm = m_mask | smask_o;
            else if (mask_update)              nm = smask_o;
            else if (m_diverges())             begin np = int'(branch_pc); nm = e; end
            else if (branch && e == m_mask)    np = int'(branch_pc);
            if (exit) m_ph = M_DONE;
            else begin
                m_pc = np; m_mask = nm;
                if (nm == 0) begin m_ph = M_DONE; m_err = 1; end
                else m_ph = M_READY;
            end
        end
    endtask

    task automatic check_outputs();
        logic [WW-1:0] exp_smi;
        exp_smi = contention ? m_mask : (m_diverges() ? (m_mask & ~taken_mask) : '0);
        check("ready", 64'(ready), 64'(m_ph == M_READY));
        check("done", 64'(done), 64'(m_ph == M_DONE));
        check("err", 64'(err), 64'(m_err));
        check("cur_pc", 64'(cur_pc), 64'(m_pc));
        check("cur_pc_p1", 64'(cur_pc_p1), 64'(pc_inc(m_pc)));
        check("cur_mask", 64'(cur_mask), 64'(m_mask));
        check("wup", 64'(wup), 64'(m_wup()));
        check("diverge", 64'(diverge), 64'(m_diverges()));
        check("stack_mask_i", 64'(stack_mask_i), 64'(exp_smi));
`ifdef WARP_CTX_PERF_EN
        check("perf_retired", 64'(perf_retired), 64'(m_ret));
        check("perf_diverge", 64'(perf_diverge), 64'(m_div));
`endif
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; issue_grant = 0; wb = 0; branch = 0; exit = 0; contention = 0;
        mask_update = 0; converge = 0; pc_update = 0;
        start_pc = '0; branch_pc = '0; pc_o = '0;
        start_mask = '0; taken_mask = '0; ldst_done_mask = '0; smask_o = '0;
    endtask

    task automatic launch(input logic [AW-1:0] pc, input logic [WW-1:0] mask);
        clear_inputs(); start = 1; start_pc = pc; start_mask = mask; tick();
        clear_inputs();
    endtask

    task automatic grant();
        clear_inputs(); issue_grant = 1; tick(); clear_inputs();
    endtask

    function automatic logic [WW-1:0] rmask(input logic [WW-1:0] base);
        case ($urandom_range(0, 4))
            0: return '0;
            1: return base;
            2: return '1;
            3: return $urandom;
            default: return base & $urandom;
        endcase
    endfunction

    initial begin
        clear_inputs();
        rst = 1;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_pc", 64'(cur_pc), 64'd0);
        check("rst_mask", 64'(cur_mask), 64'd0);
        check("rst_done_err", 64'({done, err}), 64'd0);
        rst = 0;
        @(negedge clk);

        // Launch and a plain writeback; wb held high one extra cycle
        launch(10'h010, 32'hFFFF_FFFF);
        check("launch_pc", 64'(cur_pc), 64'h010);
        grant();
        wb = 1;
        #1 check("wup_high", 64'(wup), 64'd1);
        tick();
        check("wb_pc", 64'(cur_pc), 64'h011);
        check("wb_ready", 64'(ready), 64'd1);
        check("wup_one_cycle", 64'(wup), 64'd0);
        tick();
        clear_inputs();

        // Divergence
        grant();
        wb = 1; branch = 1; branch_pc = 10'h040; taken_mask = 32'h0000_FFFF;
        #1 check("div_flag", 64'(diverge), 64'd1);
        check("div_push", 64'(stack_mask_i), 64'hFFFF_0000);
        tick();
        check("div_pc", 64'(cur_pc), 64'h040);
        check("div_mask", 64'(cur_mask), 64'h0000_FFFF);

        // Stack redirect beats a concurrent branch, then converge
        grant();
        wb = 1; pc_update = 1; pc_o = 10'h021; smask_o = 32'hFFFF_0000;
        branch = 1; branch_pc = 10'h055; taken_mask = 32'h00FF_00FF;
        tick();
        check("redir_pc", 64'(cur_pc), 64'h021);
        check("redir_mask", 64'(cur_mask), 64'hFFFF_0000);
        grant();
        wb = 1; converge = 1; smask_o = 32'h0000_FFFF;
        tick();
        check("conv_mask", 64'(cur_mask), 64'hFFFF_FFFF);
        check("conv_pc", 64'(cur_pc), 64'h022);

        // Contention replay and mask restore
        grant();
        wb = 1; mask_update = 1; smask_o = 32'h0000_00FF;
        tick();
        grant();
        wb = 1; contention = 1; ldst_done_mask = 32'h0000_000F;
        #1 check("cont_push", 64'(stack_mask_i), 64'h0000_00FF);
        tick();
        check("cont_pc", 64'(cur_pc), 64'h023);
        check("cont_mask", 64'(cur_mask), 64'h0000_00F0);
        grant();
        wb = 1; mask_update = 1; smask_o = 32'h0000_00FF;
        tick();
        check("mupd_mask", 64'(cur_mask), 64'h0000_00FF);
        check("mupd_pc", 64'(cur_pc), 64'h024);

        // Exit, then a grant in DONE is ignored
        grant();
        wb = 1; exit = 1;
        tick();
        check("exit_done", 64'(done), 64'd1);
        clear_inputs(); issue_grant = 1; tick();
        check("done_grant_ignored", 64'(done), 64'd1);

        // PC wrap
        launch(10'h3FF, 32'h0000_00FF);
        grant();
        wb = 1;
        tick();
        check("pc_wrap", 64'(cur_pc), 64'h000);

        // Mask emptied by contention without exit
        grant();
        wb = 1; contention = 1; taken_mask = '0; ldst_done_mask = 32'h0000_00FF;
        tick();
        check("empty_err", 64'(err), 64'd1);
        check("empty_done", 64'(done), 64'd1);

        // Asynchronous reset while WAIT
        launch(10'h005, 32'h0000_0003);
        grant();
        #2 rst = 1;
        #1;
        check("arst_ready", 64'(ready), 64'd0);
        check("arst_pc", 64'(cur_pc), 64'd0);
        check("arst_mask", 64'(cur_mask), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);

`ifdef WARP_CTX_PERF_EN
        launch(10'h100, 32'hFFFF_FFFF);
        grant(); wb = 1; tick();
        grant(); wb = 1; branch = 1; branch_pc = 10'h040; taken_mask = 32'h0000_FFFF; tick();
        grant(); wb = 1; contention = 1; ldst_done_mask = 32'h0000_0001; tick();
        clear_inputs();
        check("perf_ret_3wb", 64'(perf_retired), 64'd2);
        check("perf_div_3wb", 64'(perf_diverge), 64'd1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clear_inputs();
            start       = (m_ph == M_IDLE || m_ph == M_DONE) ? ($urandom_range(0, 1) == 1)
                                                             : ($urandom_range(0, 15) == 0);
            start_pc    = AW'($urandom);
            start_mask  = ($urandom_range(0, 1) == 1) ? '1 : WW'($urandom);
            issue_grant = $urandom_range(0, 1) == 1;
            wb          = $urandom_range(0, 1) == 1;
            branch      = $urandom_range(0, 1) == 1;
            branch_pc   = AW'($urandom);
            taken_mask  = rmask(m_mask);
            exit        = $urandom_range(0, 31) == 0;
            contention  = $urandom_range(0, 7) == 0;
            ldst_done_mask = rmask(m_mask);
            pc_o        = AW'($urandom);
            smask_o     = rmask(~m_mask);
            pc_update   = $urandom_range(0, 7) == 0;
            converge    = $urandom_range(0, 7) == 0;
            mask_update = $urandom_range(0, 7) == 0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
